// File: rtl/fifo_stream_reader_if.sv
// Handshake bundle between fifo_stream_reader, the sync_fifo read port and the
// downstream valid/ready sink. master = the reader, slave = its environment.
interface fifo_stream_reader_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  fifo_ren;
    logic                  fifo_rempty;
    logic [DATA_WIDTH-1:0] fifo_rdata;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_ready;

    modport master (
        output fifo_ren, out_valid, out_data,
        input  fifo_rempty, fifo_rdata, out_ready
    );

    modport slave (
        input  fifo_ren, out_valid, out_data,
        output fifo_rempty, fifo_rdata, out_ready
    );
endinterface

// File: rtl/fifo_stream_reader.sv
// Read-side master for sync_fifo: drains the FIFO read port and re-presents the
// words on a valid/ready stream. A 2-entry buffer hides the FIFO's one-cycle
// read latency so a ready sink sees one word per clock.
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en_i,
    fifo_stream_reader_if.master bus,
    output logic [CNT_WIDTH-1:0] xfer_cnt_o,
    output logic                 busy_o
);

    logic [1:0]            occ_q, occ_d;
    logic                  inflight_q;
    logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
    logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    logic                  pop;
    logic [1:0]            lvl_pre;
    logic [1:0]            tail;

    // Occupancy never exceeds 2 (occ + inflight <= 2), and pop implies occ >= 1,
    // so the 2-bit arithmetic below cannot overflow or underflow.
    assign pop     = (occ_q != 2'd0) & bus.out_ready;
    assign lvl_pre = occ_q + {1'b0, inflight_q};
    assign occ_d   = lvl_pre - {1'b0, pop};
    assign tail    = occ_q - {1'b0, pop};

    // A new read is only issued if the word it returns is guaranteed a slot,
    // counting the pop happening this very cycle; hence the path from out_ready.
    assign bus.fifo_ren = rst_n & en_i & ~bus.fifo_rempty & (occ_d < 2'd2);

    assign bus.out_valid = (occ_q != 2'd0);
    assign bus.out_data  = buf0_q;
    assign xfer_cnt_o    = cnt_q;
    assign busy_o        = (occ_q != 2'd0) | inflight_q;

    // Buffer shift on pop and capture of the returning read word at the tail.
    always_comb begin
        buf0_d = buf0_q;
        buf1_d = buf1_q;
        cnt_d  = cnt_q;
        if (pop) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
            if (occ_q == 2'd2) begin
                buf0_d = buf1_q;
            end
        end
        // With a read in flight occ <= 1, so the tail is slot 0 or slot 1.
        if (inflight_q) begin
            if (tail == 2'd0) begin
                buf0_d = bus.fifo_rdata;
            end else begin
                buf1_d = bus.fifo_rdata;
            end
        end
    end

    // State registers; reset discards buffered and in-flight words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            buf0_q     <= '0;
            buf1_q     <= '0;
            cnt_q      <= '0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= bus.fifo_ren;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule
